// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter in front of a single-ported data memory. The requesters
// are the PE load/store port (p0) and the host loader (p1). The block serves one
// transaction at a time in three phases:
//   IDLE  : pick a winner and accept its command
//   ISSUE : drive the memory for exactly one cycle (read data is captured here)
//   RESP  : hold the response until the granted requester consumes it
// When both requesters are valid at the same time, the port that did not win
// last time is granted (round-robin).
//
// Ports
//   clk, rst                    clock, synchronous active-low reset
//   pX_valid/we/addr/wdata      request channel from requester X
//   pX_ready                    request accepted this cycle (IDLE, granted port)
//   pX_rsp_valid/pX_rsp_ready   response handshake toward requester X
//   rsp_rdata                   read data, shared by both response channels
//   mem_we/mem_addr/mem_wd      data-memory command
//   mem_rd                      data-memory combinational read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              sel;
    logic              accept;
    logic              rspReady;

    // Candidate winner: on a tie the port that lost last time goes next,
    // otherwise whichever single port is valid.
    always_comb begin
        if (p0_valid && p1_valid) begin
            sel = ~last_q;
        end else begin
            sel = p1_valid;
        end
    end

    // Every handshake output is gated with rst so nothing is offered or
    // written while reset is held, including mid-transaction aborts.
    assign p0_ready     = rst && (state_q == IDLE) && p0_valid && !sel;
    assign p1_ready     = rst && (state_q == IDLE) && p1_valid && sel;
    assign accept       = p0_ready || p1_ready;

    assign p0_rsp_valid = rst && (state_q == RESP) && !gnt_q;
    assign p1_rsp_valid = rst && (state_q == RESP) && gnt_q;
    assign rspReady     = gnt_q ? p1_rsp_ready : p0_rsp_ready;

    assign mem_we       = rst && (state_q == ISSUE) && we_q;
    assign mem_addr     = addr_q;
    assign mem_wd       = wdata_q;
    assign rsp_rdata    = rdata_q;

    // Next-state logic. Read data is taken from the memory during ISSUE; a
    // write leaves the previous read data in place.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    gnt_d   = sel;
                    last_d  = sel;
                    we_d    = sel ? p1_we    : p0_we;
                    addr_d  = sel ? p1_addr  : p0_addr;
                    wdata_d = sel ? p1_wdata : p0_wdata;
                end
            end
            ISSUE: begin
                state_d = RESP;
                if (!we_q) begin
                    rdata_d = mem_rd;
                end
            end
            RESP: begin
                if (rspReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. last resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A small behavioural memory sits on the
// memory port; a reference copy of that memory plus a response queue predict
// every response. The cycle() task is the per-cycle monitor: it tracks
// accepts, the ISSUE cycle and responses, and checks protocol invariants.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_valid, p0_we, p0_ready, p0_rsp_valid, p0_rsp_ready;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p1_valid, p1_we, p1_ready, p1_rsp_valid, p1_rsp_ready;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic [DW-1:0] rsp_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_valid     (p0_valid),
        .p0_we        (p0_we),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_ready     (p0_ready),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_ready (p0_rsp_ready),
        .p1_valid     (p1_valid),
        .p1_we        (p1_we),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_ready     (p1_ready),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_ready (p1_rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    // Behavioural data memory: 16 words of 32 bytes, indexed by addr[8:5].
    logic [DW-1:0] tbMem  [0:15];
    logic [DW-1:0] refMem [0:15];

    assign mem_rd = tbMem[mem_addr[8:5]];

    always @(posedge clk) begin
        if (mem_we) tbMem[mem_addr[8:5]] <= mem_wd;
    end

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    logic          grantLog[$];
    int            checkCount = 0;
    int            passCount  = 0;
    int            memWePulses = 0;
    logic          issueNext = 1'b0;
    logic          respDue   = 1'b0;
    logic          expWe;
    logic          expPort;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWd;
    logic [DW-1:0] lastRd = '0;

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Per-cycle monitor: called just after the inputs for this cycle are
    // driven; samples, then waits for the next falling edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (!rst) begin
            checkOutput("rstQuiet", {p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, mem_we}, '0);
            sbq.delete();
            issueNext = 1'b0;
            respDue   = 1'b0;
            lastRd    = '0;
        end else begin
            checkOutput("memWe", mem_we, issueNext & expWe);
            if (mem_we) memWePulses++;
            checkOutput("readyRspExcl", (p0_ready & p0_rsp_valid) | (p1_ready & p1_rsp_valid), '0);
            checkOutput("readyOneHot", p0_ready & p1_ready, '0);
            if (respDue) begin
                checkOutput("rspLatency", expPort ? p1_rsp_valid : p0_rsp_valid, 1);
                respDue = 1'b0;
            end
            if (issueNext) begin
                checkOutput("issueAddr", mem_addr, expAddr);
                if (expWe) begin
                    checkOutput("issueWd", mem_wd, expWd);
                    refMem[expAddr[8:5]] = expWd;
                end
                issueNext = 1'b0;
                respDue   = 1'b1;
            end
            if (p0_rsp_valid || p1_rsp_valid) begin
                checkOutput("rspOneHot", p0_rsp_valid & p1_rsp_valid, '0);
                if ((p0_rsp_valid && p0_rsp_ready) || (p1_rsp_valid && p1_rsp_ready)) begin
                    checkOutput("sbNonEmpty", sbq.size() != 0, 1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        checkOutput("rspPort", p1_rsp_valid, e.port);
                        checkOutput("rspData", rsp_rdata, e.data);
                    end
                end
            end
            if ((p0_valid && p0_ready) || (p1_valid && p1_ready)) begin
                expPort = p1_ready;
                expWe   = expPort ? p1_we    : p0_we;
                expAddr = expPort ? p1_addr  : p0_addr;
                expWd   = expPort ? p1_wdata : p0_wdata;
                e.port  = expPort;
                if (expWe) begin
                    e.data = lastRd;
                end else begin
                    e.data = refMem[expAddr[8:5]];
                    lastRd = e.data;
                end
                sbq.push_back(e);
                grantLog.push_back(expPort);
                issueNext = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // One complete transaction on one port, with hold cycles of response
    // backpressure. Returns the read data seen on the consuming cycle.
    task automatic applyStimulus(input logic port, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wd, input int hold, output logic [DW-1:0] rdOut);
        int n;
        if (port) begin
            p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_rsp_ready = 1'b0;
        end else begin
            p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_rsp_ready = 1'b0;
        end
        n = 0;
        #1;
        while (!(port ? p1_ready : p0_ready) && n < 20) begin
            cycle(); #1; n++;
        end
        checkOutput("readyBound", n < 20, 1);
        cycle();
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        n = 0;
        #1;
        while (!(port ? p1_rsp_valid : p0_rsp_valid) && n < 20) begin
            cycle(); #1; n++;
        end
        checkOutput("rspBound", n < 20, 1);
        repeat (hold) begin
            checkOutput("holdRspValid", port ? p1_rsp_valid : p0_rsp_valid, 1);
            cycle(); #1;
        end
        if (port) p1_rsp_ready = 1'b1; else p0_rsp_ready = 1'b1;
        rdOut = rsp_rdata;
        cycle();
        p0_rsp_ready = 1'b0;
        p1_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] rd;
        int n;

        for (int i = 0; i < 16; i++) begin
            tbMem[i]  = {32{8'(i)}};
            refMem[i] = {32{8'(i)}};
        end
        tbMem[1]  = {32{8'hAB}};
        refMem[1] = {32{8'hAB}};
        tbMem[3]  = {32{8'hCD}};
        refMem[3] = {32{8'hCD}};

        rst = 1'b0;
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_rsp_ready = 1'b0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_rsp_ready = 1'b0;

        // Reset: outputs quiet, read data cleared.
        @(negedge clk);
        cycle();
        p0_valid = 1'b1; p1_valid = 1'b1;
        cycle();
        checkOutput("rstRdata", rsp_rdata, '0);
        p0_valid = 1'b0; p1_valid = 1'b0;
        rst = 1'b1;
        cycle();

        // Idle bus for 10 cycles.
        repeat (10) begin
            #1;
            checkOutput("idleQuiet", {p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, mem_we}, '0);
            cycle();
        end

        // Single p0 read of 0x20.
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h20; p0_rsp_ready = 1'b1;
        #1;
        checkOutput("p0ReadyT", p0_ready, 1);
        cycle();
        p0_valid = 1'b0;
        #1;
        checkOutput("readIssueNoWe", mem_we, 0);
        cycle();
        #1;
        checkOutput("p0RspValidT2", p0_rsp_valid, 1);
        checkOutput("readDataAB", rsp_rdata, {32{8'hAB}});
        cycle();
        p0_rsp_ready = 1'b0;
        cycle();

        // p1 write 0x40 = 0x1234, then read it back.
        memWePulses = 0;
        applyStimulus(1'b1, 1'b1, 32'h40, 256'h1234, 0, rd);
        checkOutput("writeKeepsRdata", rd, {32{8'hAB}});
        applyStimulus(1'b1, 1'b0, 32'h40, '0, 0, rd);
        checkOutput("wrRdBack", rd, 256'h1234);
        checkOutput("wePulseCount", memWePulses, 1);

        // Backpressure on p0 while p1 waits.
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h20; p0_rsp_ready = 1'b0;
        #1;
        checkOutput("bpP0Ready", p0_ready, 1);
        cycle();
        p0_valid = 1'b0;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h60; p1_rsp_ready = 1'b1;
        cycle();
        repeat (5) begin
            #1;
            checkOutput("bpRspHeld", p0_rsp_valid, 1);
            checkOutput("bpP1Blocked", p1_ready, 0);
            cycle();
        end
        p0_rsp_ready = 1'b1;
        #1;
        checkOutput("noAcceptOnExit", p1_ready, 0);
        cycle();
        p0_rsp_ready = 1'b0;
        #1;
        checkOutput("p1AfterRelease", p1_ready, 1);
        cycle();
        p1_valid = 1'b0;
        repeat (3) cycle();
        p1_rsp_ready = 1'b0;

        // Contention after reset: grants alternate starting with p0.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        grantLog.delete();
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h20; p0_rsp_ready = 1'b1;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h60; p1_rsp_ready = 1'b1;
        n = 0;
        while (grantLog.size() < 4 && n < 40) begin
            cycle(); n++;
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        repeat (3) cycle();
        p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b0;
        checkOutput("grantCount", grantLog.size(), 4);
        if (grantLog.size() >= 4) begin
            checkOutput("grant0", grantLog[0], 0);
            checkOutput("grant1", grantLog[1], 1);
            checkOutput("grant2", grantLog[2], 0);
            checkOutput("grant3", grantLog[3], 1);
        end

        // Reset during ISSUE of a p1 write aborts it.
        p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h40; p1_wdata = 256'h5555;
        #1;
        checkOutput("abortP1Ready", p1_ready, 1);
        cycle();
        p1_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("abortMemWe", mem_we, 0);
        cycle();
        rst = 1'b1;
        #1;
        checkOutput("abortNoRsp", {p0_rsp_valid, p1_rsp_valid}, '0);
        checkOutput("abortNoWrite", tbMem[2], 256'h1234);
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h20; p0_rsp_ready = 1'b1;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h40; p1_rsp_ready = 1'b1;
        #1;
        checkOutput("tieAfterRstP0", p0_ready, 1);
        checkOutput("tieAfterRstP1", p1_ready, 0);
        cycle();
        p0_valid = 1'b0;
        n = 0;
        #1;
        while (!p1_ready && n < 10) begin
            cycle(); #1; n++;
        end
        checkOutput("p1ServedBound", n < 10, 1);
        cycle();
        p1_valid = 1'b0;
        repeat (3) cycle();
        checkOutput("sbDrained", sbq.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
